// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort flow controller.
package sort_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_ERROR
  } state_t;

  localparam int DROP_W      = 8;
  localparam int NUM_SEQ_DEF = 10;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/sort_flow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sort_flow_ctrl.sv
// Sequences unsorted sequences into the sorter and
// tracks batch progress, drops and sorter timeouts.
module sort_flow_ctrl
  import sort_pkg::*;
#(
  parameter int NUM_SEQ     = NUM_SEQ_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int CNT_W       = $clog2(NUM_SEQ + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seq_ready_in,
  input  logic              data_end,
  input  logic              sort_valid_in,
  input  logic              tx_full,
  input  logic              clear_err,
  output logic              sort_start,
  output logic              seq_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  seq_count,
  output logic              batch_done,
  output logic [DROP_W-1:0] drop_count,
  output logic              timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_HIT =
    TO_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(NUM_SEQ);

  state_t           r_state;
  logic             r_pend;
  logic             r_end_flag;
  logic             r_sort_start;
  logic             r_busy;
  logic [CNT_W-1:0] r_seq_count;
  logic             r_batch_done;
  logic             r_timeout_err;

  logic [TO_W-1:0]  w_to_cnt;
  logic             w_to_inc;
  logic             w_to_hit;
  logic             w_drop;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  assign w_to_inc  = (r_state == S_WAIT);
  assign w_to_hit  = w_to_inc && (w_to_cnt == TO_HIT);
  assign w_cnt_nxt = r_seq_count + 1'b1;
  assign w_last    = (w_cnt_nxt == CNT_LAST);

  // Only one request can queue; later ones are lost.
  assign w_drop = seq_ready_in &&
    ((r_state == S_ERROR) ||
     (r_pend && ((r_state == S_HOLD) ||
                 (r_state == S_ISSUE) ||
                 ((r_state == S_WAIT) &&
                  !sort_valid_in))));

  sat_counter #(.W(DROP_W)) u_drop (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_inc (w_drop),
    .o_q   (drop_count)
  );

  sat_counter #(.W(TO_W)) u_tout (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_to_inc),
    .i_inc (w_to_inc),
    .o_q   (w_to_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pend        <= 1'b0;
      r_end_flag    <= 1'b0;
      r_sort_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_seq_count   <= '0;
      r_batch_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_sort_start <= 1'b0;
      r_batch_done <= 1'b0;
      if (data_end && (r_state != S_IDLE)) begin
        r_end_flag <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          r_end_flag <= 1'b0;
          if ((data_end || r_end_flag) &&
              (r_seq_count != '0)) begin
            r_batch_done <= 1'b1;
            r_seq_count  <= '0;
          end
          r_busy <= seq_ready_in;
          if (seq_ready_in) begin
            if (tx_full) begin
              r_state <= S_HOLD;
            end else begin
              r_state      <= S_ISSUE;
              r_sort_start <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (seq_ready_in && !r_pend) begin
            r_pend <= 1'b1;
          end
          if (!tx_full) begin
            r_state      <= S_ISSUE;
            r_sort_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (seq_ready_in && !r_pend) begin
            r_pend <= 1'b1;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (sort_valid_in) begin
            if (w_last) begin
              r_seq_count  <= '0;
              r_batch_done <= 1'b1;
            end else begin
              r_seq_count <= w_cnt_nxt;
            end
            if (r_pend || seq_ready_in) begin
              // A queued request goes first; a new one refills the slot.
              r_pend <= r_pend && seq_ready_in;
              if (tx_full) begin
                r_state <= S_HOLD;
              end else begin
                r_state      <= S_ISSUE;
                r_sort_start <= 1'b1;
              end
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            if (seq_ready_in && !r_pend) begin
              r_pend <= 1'b1;
            end
            if (w_to_hit) begin
              r_state       <= S_ERROR;
              r_timeout_err <= 1'b1;
            end
          end
        end
        S_ERROR: begin
          if (clear_err) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_pend        <= 1'b0;
            r_seq_count   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sort_start  = r_sort_start;
  assign seq_ack     = r_sort_start;
  assign busy        = r_busy;
  assign seq_count   = r_seq_count;
  assign batch_done  = r_batch_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_sort_flow_ctrl.sv
// Directed scoreboard bench for sort_flow_ctrl.
module tb_sort_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seq_ready_in = 1'b0;
  logic       data_end = 1'b0;
  logic       sort_valid_in = 1'b0;
  logic       tx_full = 1'b0;
  logic       clear_err = 1'b0;
  logic       sort_start;
  logic       seq_ack;
  logic       busy;
  logic [3:0] seq_count;
  logic       batch_done;
  logic [7:0] drop_count;
  logic       timeout_err;

  int ntest = 0;
  int nfail = 0;
  int cyc = 0;
  int exp_start[$];
  int exp_done[$];

  sort_flow_ctrl #(
    .NUM_SEQ     (10),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .seq_ready_in  (seq_ready_in),
    .data_end      (data_end),
    .sort_valid_in (sort_valid_in),
    .tx_full       (tx_full),
    .clear_err     (clear_err),
    .sort_start    (sort_start),
    .seq_ack       (seq_ack),
    .busy          (busy),
    .seq_count     (seq_count),
    .batch_done    (batch_done),
    .drop_count    (drop_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every start/done pulse must match a queued cycle.
  always @(negedge clk) begin
    int e;
    if (sort_start || seq_ack) begin
      e = (exp_start.size() != 0) ?
          exp_start.pop_front() : -1;
      chk("sort_start_cyc", cyc, e);
      chk("seq_ack_eq", seq_ack, sort_start);
    end
    if (batch_done) begin
      e = (exp_done.size() != 0) ?
          exp_done.pop_front() : -1;
      chk("batch_done_cyc", cyc, e);
      chk("done_cnt_zero", seq_count, 0);
    end
  end

  initial begin
    int a;
    int v;

    // Reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", seq_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_start", sort_start, 0);
    rst = 1'b1;
    tick(2);

    // Single sort, result 14 cycles later
    a = cyc;
    exp_start.push_back(a + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    chk("t1_busy_issue", busy, 1);
    tick(14);
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    chk("t1_cnt", seq_count, 1);
    chk("t1_busy", busy, 0);

    // Close partial batch of one in IDLE
    exp_done.push_back(cyc + 1);
    data_end = 1'b1; tick(1); data_end = 1'b0;
    chk("t1_close_cnt", seq_count, 0);

    // Ten back-to-back sequences
    a = cyc;
    exp_start.push_back(a + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    tick(1);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
      end else begin
        tick(1);
      end
      v = cyc;
      if (i < 9) exp_start.push_back(v + 1);
      else exp_done.push_back(v + 1);
      sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
      tick(1);
    end
    chk("t2_cnt", seq_count, 0);
    chk("t2_drop", drop_count, 0);
    chk("t2_busy", busy, 0);

    // Held by tx_full for 30 cycles
    tx_full = 1'b1;
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    chk("t3_busy_hold", busy, 1);
    tick(29);
    tx_full = 1'b0;
    exp_start.push_back(cyc + 1);
    tick(2);
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    chk("t3_cnt", seq_count, 1);

    // Three requests in one WAIT_SORT: one pends, two drop
    exp_start.push_back(cyc + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    tick(1);
    seq_ready_in = 1'b1; tick(3); seq_ready_in = 1'b0;
    chk("t4_drop", drop_count, 2);
    exp_start.push_back(cyc + 1);
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    tick(1);
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    chk("t4_cnt", seq_count, 3);
    chk("t4_busy", busy, 0);

    // Result pulse in IDLE is ignored
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    chk("idle_valid_cnt", seq_count, 3);

    // data_end after three results
    exp_done.push_back(cyc + 1);
    data_end = 1'b1; tick(1); data_end = 1'b0;
    chk("t6_cnt", seq_count, 0);

    // Result on the last allowed cycle still completes
    a = cyc;
    exp_start.push_back(a + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    tick(15);
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    chk("edge_terr", timeout_err, 0);
    chk("edge_cnt", seq_count, 1);
    chk("edge_busy", busy, 0);

    // Timeout with no result
    a = cyc;
    exp_start.push_back(a + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (timeout_err) break;
      tick(1);
    end
    chk("t5_terr_cyc", cyc, a + 17);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    chk("t5_err_drop", drop_count, 3);
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    chk("t5_terr_clr", timeout_err, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cnt", seq_count, 0);
    chk("t5_drop_kept", drop_count, 3);

    // Reset during WAIT_SORT with a pending request
    exp_start.push_back(cyc + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    tick(1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    rst = 1'b0;
    tick(1);
    chk("t7_start", sort_start, 0);
    chk("t7_ack", seq_ack, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cnt", seq_count, 0);
    chk("t7_done", batch_done, 0);
    chk("t7_drop", drop_count, 0);
    chk("t7_terr", timeout_err, 0);
    rst = 1'b1;
    tick(5);
    chk("t7_idle_busy", busy, 0);

    // Normal operation after reset
    exp_start.push_back(cyc + 1);
    seq_ready_in = 1'b1; tick(1); seq_ready_in = 1'b0;
    tick(1);
    sort_valid_in = 1'b1; tick(1); sort_valid_in = 1'b0;
    chk("t8_cnt", seq_count, 1);
    tick(2);

    chk("start_q_empty", exp_start.size(), 0);
    chk("done_q_empty", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
